// File: rtl/shift_reg_ctrl_if.sv
// Command/response bus between a requester and shift_reg_ctrl.
// Carries the command handshake, abort, serial-out stream and completion response.
interface shift_reg_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_fill;
  logic             cmd_rot;
  logic             abort;
  logic             ser_valid;
  logic             ser_bit;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_fill, cmd_rot, abort,
    input  cmd_ready, ser_valid, ser_bit, done, aborted, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_fill, cmd_rot, abort,
    output cmd_ready, ser_valid, ser_bit, done, aborted, rsp_data
  );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Sequencer for one external universal shift register.
// Takes one command at a time (hold/load/shift-right N/shift-left N), drives the
// register's sel/p_in/serial inputs, streams shifted-out bits, and reports the
// final register word with a one-cycle done pulse.
// Optional feature macro: SRC_ROTATE_EN -- when defined, cmd_rot=1 feeds the
// outgoing bit back into the vacated end; otherwise cmd_rot is ignored.
module shift_reg_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rest,
  shift_reg_ctrl_if.slave  bus,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_p_in,
  output logic             sr_s_right,
  output logic             sr_s_left,
  input  logic             sr_s_right_out,
  input  logic             sr_s_left_out,
  input  logic [WIDTH-1:0] sr_p_out
);
  localparam logic [1:0] OP_HOLD = 2'd0;
  localparam logic [1:0] OP_SHR  = 2'd1;
  localparam logic [1:0] OP_SHL  = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

`ifdef SRC_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic             rot_q, rot_d;
  logic             aborted_q, aborted_d;

  logic             out_bit;
  logic             in_bit;

  // Bit leaving the register this cycle and the bit entering the vacated end.
  always_comb begin
    out_bit = (op_q == OP_SHR) ? sr_s_left_out : sr_s_right_out;
    in_bit  = (rot_q & ROT_EN) ? out_bit : fill_q;
  end

  // State and latched-command registers.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q   <= IDLE;
      op_q      <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      fill_q    <= 1'b0;
      rot_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      rot_q     <= rot_d;
      aborted_q <= aborted_d;
    end
  end

  // Next state, command latch and register/bus output decode.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    fill_d        = fill_q;
    rot_d         = rot_q;
    aborted_d     = aborted_q;
    bus.cmd_ready = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_bit   = 1'b0;
    bus.done      = 1'b0;
    bus.aborted   = 1'b0;
    bus.rsp_data  = '0;
    sr_sel        = OP_HOLD;
    sr_p_in       = '0;
    sr_s_right    = 1'b0;
    sr_s_left     = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          data_d    = bus.cmd_data;
          cnt_d     = bus.cmd_cnt;
          fill_d    = bus.cmd_fill;
          rot_d     = bus.cmd_rot;
          aborted_d = 1'b0;
          if (bus.cmd_op == OP_LOAD)
            state_d = LOAD;
          else if (bus.cmd_op == OP_HOLD || bus.cmd_cnt == '0)
            state_d = DONE;
          else
            state_d = SHIFT;
        end
      end
      LOAD: begin
        sr_sel  = OP_LOAD;
        sr_p_in = data_q;
        state_d = DONE;
      end
      SHIFT: begin
        if (bus.abort) begin
          // Register holds this cycle; no bit leaves.
          aborted_d = 1'b1;
          state_d   = DONE;
        end else begin
          sr_sel        = op_q;
          bus.ser_valid = 1'b1;
          bus.ser_bit   = out_bit;
          if (op_q == OP_SHR) sr_s_right = in_bit;
          else                sr_s_left  = in_bit;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = DONE;
        end
      end
      DONE: begin
        bus.done     = 1'b1;
        bus.aborted  = aborted_q;
        bus.rsp_data = sr_p_out;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl with a behavioural universal shift register
// attached to its register-side ports.
module tb_shift_reg_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rest = 1'b1;
  always #5 clk = ~clk;

  shift_reg_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  logic [1:0]       sr_sel;
  logic [WIDTH-1:0] sr_p_in;
  logic             sr_s_right, sr_s_left;
  logic [WIDTH-1:0] sr_q = '0;

  shift_reg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rest           (rest),
    .bus            (bus.slave),
    .sr_sel         (sr_sel),
    .sr_p_in        (sr_p_in),
    .sr_s_right     (sr_s_right),
    .sr_s_left      (sr_s_left),
    .sr_s_right_out (sr_q[WIDTH-1]),
    .sr_s_left_out  (sr_q[0]),
    .sr_p_out       (sr_q)
  );

  // External universal shift register (no reset: contents survive controller reset).
  always @(posedge clk) begin
    case (sr_sel)
      2'd1: sr_q <= {sr_s_right, sr_q[WIDTH-1:1]};
      2'd2: sr_q <= {sr_q[WIDTH-2:0], sr_s_left};
      2'd3: sr_q <= sr_p_in;
      default: sr_q <= sr_q;
    endcase
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] data,
                      input logic [2:0] cnt, input logic fill, input logic rot);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_cnt   = cnt;
    bus.cmd_fill  = fill;
    bus.cmd_rot   = rot;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  logic [3:0] rot_exp;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.cmd_cnt   = '0;
    bus.cmd_fill  = 1'b0;
    bus.cmd_rot   = 1'b0;
    bus.abort     = 1'b0;
`ifdef SRC_ROTATE_EN
    rot_exp = 4'hC;
`else
    rot_exp = 4'h8;
`endif

    // Reset values
    #2;
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_sel", sr_sel, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rsp", bus.rsp_data, 0);
    chk("rst_serv", bus.ser_valid, 0);
    chk("rst_abt", bus.aborted, 0);
    tick();
    rest = 1'b0;
    tick();

    // LOAD 4'hA: one load cycle, done at T+2
    send(2'd3, 4'hA, 3'd0, 1'b0, 1'b0);
    chk("ld_sel", sr_sel, 3);
    chk("ld_pin", sr_p_in, 4'hA);
    chk("ld_busy", bus.cmd_ready, 0);
    chk("ld_nodone", bus.done, 0);
    tick();
    chk("ld_done", bus.done, 1);
    chk("ld_rsp", bus.rsp_data, 4'hA);
    chk("ld_abt", bus.aborted, 0);
    chk("ld_hold", sr_sel, 0);
    tick();
    chk("ld_idle", bus.cmd_ready, 1);
    chk("ld_done0", bus.done, 0);

    // SHIFT_R cnt=2 fill=1 from 4'hA: bits out 0,1 -> 4'hE
    send(2'd1, 4'h0, 3'd2, 1'b1, 1'b0);
    chk("shr1_sel", sr_sel, 1);
    chk("shr1_sv", bus.ser_valid, 1);
    chk("shr1_bit", bus.ser_bit, 0);
    chk("shr1_sin", sr_s_right, 1);
    tick();
    chk("shr2_sv", bus.ser_valid, 1);
    chk("shr2_bit", bus.ser_bit, 1);
    chk("shr2_done", bus.done, 0);
    tick();
    chk("shr_done", bus.done, 1);
    chk("shr_rsp", bus.rsp_data, 4'hE);
    chk("shr_sv0", bus.ser_valid, 0);
    tick();

    // LOAD 4'h9, SHIFT_L cnt=3 rot=1 fill=0
    send(2'd3, 4'h9, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    send(2'd2, 4'h0, 3'd3, 1'b0, 1'b1);
    chk("shl1_sel", sr_sel, 2);
    chk("shl1_bit", bus.ser_bit, 1);
    tick();
    tick();
    tick();
    chk("shl_done", bus.done, 1);
    chk("shl_rsp", bus.rsp_data, rot_exp);
    tick();

    // SHIFT_R cnt=5 from 4'hF, abort in 3rd shift cycle -> 2 shifts -> 4'h3
    send(2'd3, 4'hF, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    send(2'd1, 4'h0, 3'd5, 1'b0, 1'b0);
    chk("ab1_sv", bus.ser_valid, 1);
    tick();
    chk("ab2_sv", bus.ser_valid, 1);
    tick();
    bus.abort = 1'b1;
    #1;
    chk("ab3_sel", sr_sel, 0);
    chk("ab3_sv", bus.ser_valid, 0);
    chk("ab3_done", bus.done, 0);
    tick();
    bus.abort = 1'b0;
    chk("ab_done", bus.done, 1);
    chk("ab_abt", bus.aborted, 1);
    chk("ab_rsp", bus.rsp_data, 4'h3);
    tick();
    chk("ab_idle", bus.cmd_ready, 1);

    // HOLD with cmd_valid kept high: done at T+1, no accept in DONE
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    tick();
    bus.cmd_op   = 2'd3;
    bus.cmd_data = 4'h5;
    chk("hold_done", bus.done, 1);
    chk("hold_rsp", bus.rsp_data, 4'h3);
    chk("hold_sv", bus.ser_valid, 0);
    chk("hold_busy", bus.cmd_ready, 0);
    chk("hold_abt", bus.aborted, 0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("hold_nold", sr_sel, 0);
    chk("hold_reg", sr_q, 4'h3);
    #1;
    chk("hold_idle", bus.cmd_ready, 1);

    // SHIFT_L cnt=0: done at T+1, nothing shifted
    send(2'd2, 4'h0, 3'd0, 1'b1, 1'b0);
    chk("z_done", bus.done, 1);
    chk("z_sv", bus.ser_valid, 0);
    chk("z_rsp", bus.rsp_data, 4'h3);
    tick();

    // Reset pulsed mid-SHIFT: outputs return at once, no done
    send(2'd1, 4'h0, 3'd5, 1'b1, 1'b0);
    chk("rm_sv", bus.ser_valid, 1);
    rest = 1'b1;
    #1;
    chk("rm_ready", bus.cmd_ready, 1);
    chk("rm_sel", sr_sel, 0);
    chk("rm_sv0", bus.ser_valid, 0);
    chk("rm_sin", sr_s_right, 0);
    chk("rm_done", bus.done, 0);
    tick();
    rest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rm_nodone", bus.done, 0);
      chk("rm_idle", bus.cmd_ready, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
